// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Frame state encoding, word-length codes, per-frame configuration and parity.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Line-control fields captured once per frame so mid-frame writes cannot corrupt it.
  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sticky;
  } frame_cfg_t;

  // Data is expected pre-masked to the active word length.
  function automatic logic parity_bit(input logic [7:0] data, input logic eps, input logic sticky);
    if (sticky) begin
      return ~eps;
    end
    return eps ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered read port and drop-on-full writes.
// CAP limits usable entries below DEPTH (CAP=1 gives single holding-register behaviour).
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CAP   = DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic [WIDTH-1:0]             din,
  input  logic                         rd,
  input  logic                         clr,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             ovf_reg;
  logic             do_rd;
  logic             do_wr;

  assign full  = (level_reg == LW'(CAP));
  assign empty = (level_reg == '0);
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands then.
  assign do_rd = rd && !empty && !clr;
  assign do_wr = wr && !clr && (!full || do_rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      ovf_reg <= wr && !clr && !do_wr;
      if (clr) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (do_wr && !do_rd) begin
          level_reg <= level_reg + 1'b1;
        end else if (do_rd && !do_wr) begin
          level_reg <= level_reg - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= din;
    if (do_rd) dout_reg <= mem[rd_ptr_reg];
  end

  assign dout  = dout_reg;
  assign level = level_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/uart_tx_fifo_engine.sv
// 16550-style transmitter: TX FIFO feeding a framing FSM timed by oversample ticks.
// Popped byte arrives one cycle later, so it is masked and loaded at the end of START.
module uart_tx_fifo_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter bit FIFO_EN    = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              baud_pulse,
  input  logic                              wr_en,
  input  logic [7:0]                        din,
  input  logic                              fifo_clr,
  input  logic [1:0]                        wls,
  input  logic                              stb,
  input  logic                              pen,
  input  logic                              eps,
  input  logic                              sticky_parity,
  input  logic                              set_break,
  output logic                              tx,
  output logic                              thre,
  output logic                              temt,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              wr_ovf
);

  localparam int TW  = $clog2(2 * OVERSAMPLE + 1);
  localparam int CAP = FIFO_EN ? FIFO_DEPTH : 1;

  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        pop;

  tx_state_t   state_reg, state_next;
  frame_cfg_t  cfg_reg, cfg_next, cfg_in;
  logic [TW-1:0] timer_reg, timer_next;
  logic [TW-1:0] bit_limit;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        par_reg, par_next;
  logic        tx_reg;
  logic        tx_bit;
  logic        bit_end;
  logic [7:0]  data_masked;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CAP   (CAP)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr_en),
    .din   (din),
    .rd    (pop),
    .clr   (fifo_clr),
    .dout  (fifo_dout),
    .full  (full),
    .empty (fifo_empty),
    .level (level),
    .ovf   (wr_ovf)
  );

  assign cfg_in = '{wls: wls, stb: stb, pen: pen, eps: eps, sticky: sticky_parity};

  // Bits above the latched word length never reach the shifter or the parity.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign data_masked[gi] = fifo_dout[gi] & (3'(gi) <= (3'd4 + {1'b0, cfg_reg.wls}));
    end
  endgenerate

  always_comb begin
    bit_limit = TW'(OVERSAMPLE);
    if (state_reg == STOP && cfg_reg.stb) begin
      bit_limit = (cfg_reg.wls == WLS_5) ? TW'(3 * OVERSAMPLE / 2) : TW'(2 * OVERSAMPLE);
    end
  end

  assign bit_end = baud_pulse && (state_reg != IDLE) && (timer_reg == bit_limit - 1'b1);

  always_comb begin
    state_next   = state_reg;
    cfg_next     = cfg_reg;
    timer_next   = timer_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    par_next     = par_reg;
    pop          = 1'b0;

    if (state_reg != IDLE && baud_pulse) timer_next = timer_reg + 1'b1;
    if (bit_end) timer_next = '0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty && !fifo_clr) begin
          pop        = 1'b1;
          cfg_next   = cfg_in;
          timer_next = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          shift_next   = data_masked;
          par_next     = parity_bit(data_masked, cfg_reg.eps, cfg_reg.sticky);
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == (3'd4 + {1'b0, cfg_reg.wls})) begin
            state_next = cfg_reg.pen ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (bit_end) begin
          if (!fifo_empty && !fifo_clr) begin
            pop        = 1'b1;
            cfg_next   = cfg_in;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    case (state_reg)
      START:   tx_bit = 1'b0;
      DATA:    tx_bit = shift_reg[0];
      PARITY:  tx_bit = par_reg;
      default: tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cfg_reg     <= '0;
      timer_reg   <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      par_reg     <= 1'b0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cfg_reg     <= cfg_next;
      timer_reg   <= timer_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      par_reg     <= par_next;
      tx_reg      <= set_break ? 1'b0 : tx_bit;
    end
  end

  assign tx   = tx_reg;
  assign thre = fifo_empty;
  assign temt = (state_reg == IDLE) && fifo_empty;

endmodule
